cache_perf_counter_bank: RTL and testbench
==========================================

Name: cache_perf_counter_bank

Overview:
- Parametrised performance-counter bank for the L2 cache. Replaces ad-hoc bench read/write/hit/miss counters with synthesizable RTL.
- Monitors NUM_CH processor/trace channels. Each channel carries a command stream (n code, valid) and a snoop/lookup result stream (C code, valid).
- Classifies every event into per-channel counters with a shadow snapshot, and exposes them through a req/ack readout port to the bench or a debug bus.

Parameters:
- NUM_CH, 2, number of monitored channels (1..8)
- CNT_W, 16, counter width in bits (8..32)
- NUM_CNT, 8, counters per channel (fixed at 8; localparam in package)

Ports:
- clk  in  1  clock
- rstb  in  1  asynchronous active-low reset
- cmd_valid  in  NUM_CH  per-channel command strobe
- cmd_n  in  NUM_CH*4  per-channel command code; channel k uses bits [4k+3:4k]
- res_valid  in  NUM_CH  per-channel lookup-result strobe
- res_c  in  NUM_CH*2  per-channel result code (00 HIT, 01 HITM, 1x NOHIT)
- clr_all  in  1  synchronous clear of all live counters
- snap_req  in  1  copy all live counters to shadow
- rd_req  in  1  readout request
- rd_ch  in  3  channel to read
- rd_sel  in  3  counter index to read
- rd_ack  out  1  one-cycle pulse; rd_data/rd_err valid
- rd_data  out  CNT_W  shadow counter value
- rd_err  out  1  rd_ch >= NUM_CH
- ovf  out  NUM_CH  sticky per-channel overflow flag

Behaviour:
- Reset (rstb low, async): all live counters, shadow counters, ovf, rd_ack, rd_data and rd_err go to 0. Readout FSM goes to IDLE.
- Counter index map per channel. Command counters increment on cmd_valid:
  - 0 READ_D: n=0
  - 1 WRITE_D: n=1
  - 2 READ_I: n=2
  - 3 SNOOP: n=3..6
  - 7 BAD_CMD: n=7 or n>9
- Result counters increment on res_valid:
  - 4 HIT: C=00
  - 5 HITM: C=01
  - 6 NOHIT: C=1x
- n=8 (CLR_CACHE_RST) on channel k clears that channel's live counters and ovf[k] on the next edge. Its own event is not counted.
- n=9 (PRINT_CONTENTS) on any channel acts as a snap_req. It is not counted.
- Command and result strobes on the same channel and cycle each increment their own counter. Both are counted, with 1-cycle update latency.
- Priority per channel, highest first: clr_all, then channel n=8 clear, then increment. An increment coincident with a clear is dropped.
- Snapshot captures the pre-edge live values, i.e. values before any same-cycle clear or increment. Shadow is visible to readout from the following cycle.
- Overflow: an increment at all-ones wraps to 0 and sets the sticky ovf[k]. ovf[k] clears only on reset, clr_all or a channel n=8.
- Readout FSM:
  - IDLE: rd_req=1 latches rd_ch/rd_sel and moves to RESP.
  - RESP: rd_ack=1 for exactly one cycle with rd_data = shadow[rd_ch][rd_sel], then returns to IDLE.
  - rd_req held high issues back-to-back reads at one every 2 cycles. rd_req in RESP is ignored.
  - rd_ch >= NUM_CH: rd_data=0, rd_err=1 with the ack.
  - rd_data and rd_err hold their values between acks.
- Snapshot during RESP does not alter the data already latched for the current ack.

Optional Feature:
- Macro PERF_CNT_SAT_EN.
- Defined: counters saturate at all-ones and do not wrap; ovf[k] still sets on the first attempted increment past all-ones.
- Undefined: counters wrap modulo 2^CNT_W as described above.

Decomposition:
- Package cache_perf_pkg holds:
  - localparam NUM_CNT=8
  - enum perf_idx_t (CNT_READ_D … CNT_BAD_CMD)
  - enum rd_state_t (IDLE, RESP)
  - function classify_cmd(n) returning an index plus a count/clear/snap flag
- One sub-module, perf_ch_counters: owns one channel's 8 live counters, the clear and increment logic, and ovf. It is instantiated NUM_CH times in a generate loop.
- The top level owns the shadow array, the snapshot OR-reduction and the readout FSM.

Test Plan:
- Reset, then channel 0 issues n=0,0,1,2,4, then snap_req, then read (ch0, sel 0..3) -> rd_data 2,1,1,1; rd_ack pulses once per read, 2 cycles apart.
- Channel 1 res_c sequence 00,01,10,11,00, then n=9 on ch1, then read sel 4/5/6 -> 2/1/2; channel 0 shadow stays 0.
- With CNT_W=8, 256 READ_D on ch0 -> live=0 and ovf[0]=1. With PERF_CNT_SAT_EN -> live=255 and ovf[0]=1.
- Same cycle: clr_all=1, snap_req=1, ch0 cmd n=0 with live READ_D=5 -> shadow=5, live=0, increment dropped.
- n=8 on ch1 while ch0 has counts -> ch1 counters and ovf[1] clear; ch0 unchanged. n=7 and n=12 -> BAD_CMD=2.
- rd_ch=5 with NUM_CH=2 -> rd_ack=1, rd_err=1, rd_data=0. Assert rstb low while in RESP -> rd_ack=0 immediately and FSM returns to IDLE.

Source files
------------

// File: rtl/cache_perf_counter_bank_pkg.sv
// cache_perf_pkg: shared types and the command/result classifiers for the
// L2 cache performance-counter bank.
//   NUM_CNT       counters per channel (fixed at 8)
//   perf_idx_t    counter index map inside one channel
//   rd_state_t    readout FSM states
//   classify_cmd  command code -> counter index plus count/clear/snap flags
//   classify_res  lookup result code -> counter index
package cache_perf_pkg;

  localparam int NUM_CNT = 8;

  typedef enum logic [2:0] {
    CNT_READ_D  = 3'd0,
    CNT_WRITE_D = 3'd1,
    CNT_READ_I  = 3'd2,
    CNT_SNOOP   = 3'd3,
    CNT_HIT     = 3'd4,
    CNT_HITM    = 3'd5,
    CNT_NOHIT   = 3'd6,
    CNT_BAD_CMD = 3'd7
  } perf_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } rd_state_t;

  typedef struct packed {
    perf_idx_t idx;
    logic      cnt;
    logic      clr;
    logic      snap;
  } cmd_class_t;

  // n=8 (channel clear) and n=9 (snapshot) are control codes, never counted.
  function automatic cmd_class_t classify_cmd(input logic [3:0] n);
    cmd_class_t c;
    c.idx  = CNT_BAD_CMD;
    c.cnt  = 1'b1;
    c.clr  = 1'b0;
    c.snap = 1'b0;
    case (n)
      4'd0:                   c.idx = CNT_READ_D;
      4'd1:                   c.idx = CNT_WRITE_D;
      4'd2:                   c.idx = CNT_READ_I;
      4'd3, 4'd4, 4'd5, 4'd6: c.idx = CNT_SNOOP;
      4'd8: begin
        c.cnt = 1'b0;
        c.clr = 1'b1;
      end
      4'd9: begin
        c.cnt  = 1'b0;
        c.snap = 1'b1;
      end
      default: c.idx = CNT_BAD_CMD;
    endcase
    return c;
  endfunction

  function automatic perf_idx_t classify_res(input logic [1:0] c);
    if (c[1])      return CNT_NOHIT;
    else if (c[0]) return CNT_HITM;
    else           return CNT_HIT;
  endfunction

endpackage

// File: rtl/cache_perf_counter_bank_ch_counters.sv
// perf_ch_counters: the eight live event counters and the sticky overflow
// flag of one monitored channel.
// Optional build macro: PERF_CNT_SAT_EN (counters saturate instead of wrap).
// Ports:
//   clk, rstb      clock, async active-low reset
//   i_clr_all      global clear (highest priority)
//   i_cmd_valid    command strobe, i_cmd_n command code
//   i_res_valid    lookup-result strobe, i_res_c result code
//   o_cnt          live counter values, index per perf_idx_t
//   o_ovf          sticky overflow flag
//   o_snap         this channel issued a snapshot command (n=9)
module perf_ch_counters
  import cache_perf_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            i_clr_all,
  input  logic                            i_cmd_valid,
  input  logic [3:0]                      i_cmd_n,
  input  logic                            i_res_valid,
  input  logic [1:0]                      i_res_c,
  output logic [NUM_CNT-1:0][CNT_W-1:0]   o_cnt,
  output logic                            o_ovf,
  output logic                            o_snap
);

  logic [NUM_CNT-1:0][CNT_W-1:0] r_cnt;
  logic                          r_ovf;
  cmd_class_t                    w_cls;
  perf_idx_t                     w_res_idx;
  logic [NUM_CNT-1:0]            w_inc;
  logic                          w_clr;

  // Command and result indices never overlap, so each counter sees at most
  // one increment per cycle.
  always_comb begin
    w_cls     = classify_cmd(i_cmd_n);
    w_res_idx = classify_res(i_res_c);
    w_clr     = i_clr_all | (i_cmd_valid & w_cls.clr);
    w_inc     = '0;
    if (i_cmd_valid && w_cls.cnt) w_inc[w_cls.idx] = 1'b1;
    if (i_res_valid)              w_inc[w_res_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_clr) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (w_inc[i]) begin
          if (&r_cnt[i]) begin
            r_ovf <= 1'b1;
`ifdef PERF_CNT_SAT_EN
            r_cnt[i] <= r_cnt[i];
`else
            r_cnt[i] <= '0;
`endif
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_ovf  = r_ovf;
  assign o_snap = i_cmd_valid & w_cls.snap;

endmodule

// File: rtl/cache_perf_counter_bank.sv
// cache_perf_counter_bank: per-channel L2 cache performance counters with a
// shadow snapshot and a req/ack readout port.
// Optional build macro: PERF_CNT_SAT_EN (saturating counters).
// Ports:
//   clk, rstb                clock, async active-low reset
//   cmd_valid/cmd_n          per-channel command strobe and 4-bit code
//   res_valid/res_c          per-channel lookup strobe and 2-bit result
//   clr_all                  clear all live counters and overflow flags
//   snap_req                 copy live counters into the shadow array
//   rd_req/rd_ch/rd_sel      readout request, channel and counter index
//   rd_ack/rd_data/rd_err    one-cycle ack with shadow value / bad-channel flag
//   ovf                      sticky per-channel overflow
//
// Readout FSM:
//   state | meaning
//   IDLE  | waiting for rd_req; on request latch data/err and raise rd_ack
//   RESP  | rd_ack high for this one cycle; rd_req ignored
module cache_perf_counter_bank
  import cache_perf_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic [NUM_CH-1:0]     cmd_valid,
  input  logic [NUM_CH*4-1:0]   cmd_n,
  input  logic [NUM_CH-1:0]     res_valid,
  input  logic [NUM_CH*2-1:0]   res_c,
  input  logic                  clr_all,
  input  logic                  snap_req,
  input  logic                  rd_req,
  input  logic [2:0]            rd_ch,
  input  logic [2:0]            rd_sel,
  output logic                  rd_ack,
  output logic [CNT_W-1:0]      rd_data,
  output logic                  rd_err,
  output logic [NUM_CH-1:0]     ovf
);

  logic [NUM_CNT-1:0][CNT_W-1:0] w_live   [NUM_CH];
  logic [NUM_CNT-1:0][CNT_W-1:0] r_shadow [NUM_CH];
  logic [NUM_CH-1:0]             w_ch_snap;
  logic                          w_snap;
  logic [CNT_W-1:0]              w_rd_word;
  logic                          w_rd_bad;
  rd_state_t                     r_state;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    perf_ch_counters #(.CNT_W(CNT_W)) u_ch (
      .clk         (clk),
      .rstb        (rstb),
      .i_clr_all   (clr_all),
      .i_cmd_valid (cmd_valid[k]),
      .i_cmd_n     (cmd_n[4*k +: 4]),
      .i_res_valid (res_valid[k]),
      .i_res_c     (res_c[2*k +: 2]),
      .o_cnt       (w_live[k]),
      .o_ovf       (ovf[k]),
      .o_snap      (w_ch_snap[k])
    );
  end

  assign w_snap = snap_req | (|w_ch_snap);

  // Shadow takes the registered live values, i.e. what they were before any
  // clear or increment landing on the same edge.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int k = 0; k < NUM_CH; k++) r_shadow[k] <= '0;
    end else if (w_snap) begin
      for (int k = 0; k < NUM_CH; k++) r_shadow[k] <= w_live[k];
    end
  end

  // Compare-based mux so an out-of-range rd_ch never indexes the array.
  always_comb begin
    w_rd_word = '0;
    w_rd_bad  = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_ch == 3'(k)) begin
        w_rd_word = r_shadow[k][rd_sel];
        w_rd_bad  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= IDLE;
      rd_ack  <= 1'b0;
      rd_data <= '0;
      rd_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (rd_req) begin
            r_state <= RESP;
            rd_ack  <= 1'b1;
            rd_data <= w_rd_word;
            rd_err  <= w_rd_bad;
          end
        end
        RESP: begin
          r_state <= IDLE;
          rd_ack  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          rd_ack  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_perf_counter_bank.sv
module tb_cache_perf_counter_bank;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;
  localparam int CNT_W8 = 8;
`ifdef PERF_CNT_SAT_EN
  localparam logic [7:0] EXP8_256 = 8'd255;
  localparam logic [7:0] EXP8_257 = 8'd255;
`else
  localparam logic [7:0] EXP8_256 = 8'd0;
  localparam logic [7:0] EXP8_257 = 8'd1;
`endif

  logic                clk = 1'b0;
  logic                rstb;
  logic [NUM_CH-1:0]   cmd_valid;
  logic [NUM_CH*4-1:0] cmd_n;
  logic [NUM_CH-1:0]   res_valid;
  logic [NUM_CH*2-1:0] res_c;
  logic                clr_all, snap_req, rd_req;
  logic [2:0]          rd_ch, rd_sel;
  logic                rd_ack, rd_err, rd_ack8, rd_err8;
  logic [CNT_W-1:0]    rd_data;
  logic [CNT_W8-1:0]   rd_data8;
  logic [NUM_CH-1:0]   ovf, ovf8;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cache_perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstb(rstb), .cmd_valid(cmd_valid), .cmd_n(cmd_n),
    .res_valid(res_valid), .res_c(res_c), .clr_all(clr_all), .snap_req(snap_req),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_err(rd_err), .ovf(ovf));

  cache_perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W8)) dut8 (
    .clk(clk), .rstb(rstb), .cmd_valid(cmd_valid), .cmd_n(cmd_n),
    .res_valid(res_valid), .res_c(res_c), .clr_all(clr_all), .snap_req(snap_req),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_ack(rd_ack8),
    .rd_data(rd_data8), .rd_err(rd_err8), .ovf(ovf8));

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input int ch, input logic [3:0] n);
    cmd_valid[ch] = 1'b1;
    cmd_n[4*ch +: 4] = n;
    tick();
    cmd_valid = '0;
    cmd_n = '0;
  endtask

  task automatic drive_res(input int ch, input logic [1:0] c);
    res_valid[ch] = 1'b1;
    res_c[2*ch +: 2] = c;
    tick();
    res_valid = '0;
    res_c = '0;
  endtask

  task automatic do_snap;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] ch, input logic [2:0] sel,
                         output logic [CNT_W-1:0] d, output logic [CNT_W8-1:0] d8,
                         output logic e, output logic ok);
    rd_ch = ch;
    rd_sel = sel;
    rd_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 4 && !ok; i++) begin
      tick();
      if (rd_ack === 1'b1 && rd_ack8 === 1'b1) ok = 1'b1;
    end
    d = rd_data;
    d8 = rd_data8;
    e = rd_err;
    rd_req = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rstb = 1'b0;
    cmd_valid = '0; cmd_n = '0; res_valid = '0; res_c = '0;
    clr_all = 1'b0; snap_req = 1'b0; rd_req = 1'b0; rd_ch = '0; rd_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (rd_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", rd_ack); else n_pass++;
    n_chk++; if (rd_data !== '0 || rd_err !== 1'b0) $display("FAIL reset_data: got %0d/%b want 0/0", rd_data, rd_err); else n_pass++;
    n_chk++; if (ovf !== '0 || ovf8 !== '0) $display("FAIL reset_ovf: got %b/%b want 00/00", ovf, ovf8); else n_pass++;
    #3 rstb = 1'b1;
    tick();
  endtask

  task automatic test_cmd_counts;
    logic [CNT_W-1:0] d; logic [CNT_W8-1:0] d8; logic e, ok;
    int exp_v [4] = '{2, 1, 1, 1};
    drive_cmd(0, 4'd0); drive_cmd(0, 4'd0); drive_cmd(0, 4'd1);
    drive_cmd(0, 4'd2); drive_cmd(0, 4'd4);
    do_read(3'd0, 3'd0, d, d8, e, ok);
    n_chk++; if (!ok || d !== 16'd0) $display("FAIL pre_snap_shadow: ack %b got %0d want 0", ok, d); else n_pass++;
    do_snap();
    for (int i = 0; i < 4; i++) begin
      do_read(3'd0, 3'(i), d, d8, e, ok);
      n_chk++;
      if (!ok || d !== CNT_W'(exp_v[i]) || e !== 1'b0)
        $display("FAIL cmd_ch0_sel%0d: ack %b got %0d err %b want %0d", i, ok, d, e, exp_v[i]);
      else n_pass++;
    end
  endtask

  task automatic test_res_counts;
    logic [CNT_W-1:0] d; logic [CNT_W8-1:0] d8; logic e, ok;
    int exp_v [3] = '{2, 1, 2};
    drive_res(1, 2'b00); drive_res(1, 2'b01); drive_res(1, 2'b10);
    drive_res(1, 2'b11); drive_res(1, 2'b00);
    drive_cmd(1, 4'd9);
    for (int i = 0; i < 3; i++) begin
      do_read(3'd1, 3'(4 + i), d, d8, e, ok);
      n_chk++;
      if (!ok || d !== CNT_W'(exp_v[i]))
        $display("FAIL res_ch1_sel%0d: ack %b got %0d want %0d", 4 + i, ok, d, exp_v[i]);
      else n_pass++;
    end
    do_read(3'd0, 3'd4, d, d8, e, ok);
    n_chk++; if (!ok || d !== 16'd0) $display("FAIL res_ch0_hit: got %0d want 0", d); else n_pass++;
    do_read(3'd1, 3'd0, d, d8, e, ok);
    n_chk++; if (!ok || d !== 16'd0) $display("FAIL n9_not_counted: got %0d want 0", d); else n_pass++;
  endtask

  task automatic test_overflow;
    logic [CNT_W-1:0] d; logic [CNT_W8-1:0] d8; logic e, ok;
    drive_cmd(0, 4'd8);
    cmd_valid[0] = 1'b1;
    cmd_n[3:0] = 4'd0;
    repeat (256) tick();
    cmd_valid = '0;
    do_snap();
    do_read(3'd0, 3'd0, d, d8, e, ok);
    n_chk++; if (!ok || d !== 16'd256) $display("FAIL ovf_w16_val: got %0d want 256", d); else n_pass++;
    n_chk++; if (d8 !== EXP8_256) $display("FAIL ovf_w8_val: got %0d want %0d", d8, EXP8_256); else n_pass++;
    n_chk++; if (ovf8 !== 2'b01 || ovf !== 2'b00) $display("FAIL ovf_flag: got %b/%b want 01/00", ovf8, ovf); else n_pass++;
    drive_cmd(0, 4'd0);
    do_snap();
    do_read(3'd0, 3'd0, d, d8, e, ok);
    n_chk++; if (!ok || d8 !== EXP8_257 || d !== 16'd257) $display("FAIL ovf_past_top: got %0d/%0d want %0d/257", d8, d, EXP8_257); else n_pass++;
    n_chk++; if (ovf8[0] !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf8[0]); else n_pass++;
    drive_cmd(0, 4'd8);
    n_chk++; if (ovf8 !== 2'b00) $display("FAIL ovf_ch_clear: got %b want 00", ovf8); else n_pass++;
  endtask

  task automatic test_clr_all;
    logic [CNT_W-1:0] d; logic [CNT_W8-1:0] d8; logic e, ok;
    repeat (5) drive_cmd(0, 4'd0);
    clr_all = 1'b1; snap_req = 1'b1;
    cmd_valid[0] = 1'b1; cmd_n[3:0] = 4'd0;
    tick();
    clr_all = 1'b0; snap_req = 1'b0; cmd_valid = '0;
    do_read(3'd0, 3'd0, d, d8, e, ok);
    n_chk++; if (!ok || d !== 16'd5 || d8 !== 8'd5) $display("FAIL clr_snap_pre: got %0d/%0d want 5/5", d, d8); else n_pass++;
    do_read(3'd1, 3'd4, d, d8, e, ok);
    n_chk++; if (!ok || d !== 16'd2) $display("FAIL clr_snap_ch1: got %0d want 2", d); else n_pass++;
    do_snap();
    do_read(3'd0, 3'd0, d, d8, e, ok);
    n_chk++; if (!ok || d !== 16'd0) $display("FAIL clr_live_zero: got %0d want 0", d); else n_pass++;
    do_read(3'd1, 3'd4, d, d8, e, ok);
    n_chk++; if (!ok || d !== 16'd0) $display("FAIL clr_ch1_zero: got %0d want 0", d); else n_pass++;
  endtask

  task automatic test_ch_clear;
    logic [CNT_W-1:0] d; logic [CNT_W8-1:0] d8; logic e, ok;
    repeat (3) drive_cmd(0, 4'd0);
    repeat (2) drive_cmd(1, 4'd1);
    res_valid[1] = 1'b1; res_c[3:2] = 2'b00;
    repeat (256) tick();
    res_valid = '0;
    n_chk++; if (ovf8 !== 2'b10) $display("FAIL ch1_ovf_set: got %b want 10", ovf8); else n_pass++;
    drive_cmd(0, 4'd7);
    drive_cmd(0, 4'd12);
    drive_cmd(1, 4'd8);
    n_chk++; if (ovf8 !== 2'b00) $display("FAIL ch1_ovf_clear: got %b want 00", ovf8); else n_pass++;
    do_snap();
    do_read(3'd0, 3'd0, d, d8, e, ok);
    n_chk++; if (!ok || d !== 16'd3) $display("FAIL ch0_kept: got %0d want 3", d); else n_pass++;
    do_read(3'd0, 3'd7, d, d8, e, ok);
    n_chk++; if (!ok || d !== 16'd2) $display("FAIL bad_cmd: got %0d want 2", d); else n_pass++;
    do_read(3'd1, 3'd1, d, d8, e, ok);
    n_chk++; if (!ok || d !== 16'd0) $display("FAIL ch1_wr_clear: got %0d want 0", d); else n_pass++;
    do_read(3'd1, 3'd4, d, d8, e, ok);
    n_chk++; if (!ok || d !== 16'd0) $display("FAIL ch1_hit_clear: got %0d want 0", d); else n_pass++;
  endtask

  task automatic test_same_cycle;
    logic [CNT_W-1:0] d; logic [CNT_W8-1:0] d8; logic e, ok;
    cmd_valid[1] = 1'b1; cmd_n[7:4] = 4'd1;
    res_valid[1] = 1'b1; res_c[3:2] = 2'b01;
    tick();
    cmd_valid = '0; cmd_n = '0; res_valid = '0; res_c = '0;
    do_snap();
    do_read(3'd1, 3'd1, d, d8, e, ok);
    n_chk++; if (!ok || d !== 16'd1) $display("FAIL same_cyc_cmd: got %0d want 1", d); else n_pass++;
    do_read(3'd1, 3'd5, d, d8, e, ok);
    n_chk++; if (!ok || d !== 16'd1) $display("FAIL same_cyc_res: got %0d want 1", d); else n_pass++;
    drive_cmd(1, 4'd1);
    rd_ch = 3'd1; rd_sel = 3'd1; rd_req = 1'b1;
    tick();
    n_chk++; if (rd_ack !== 1'b1 || rd_data !== 16'd1) $display("FAIL resp_ack: got %b/%0d want 1/1", rd_ack, rd_data); else n_pass++;
    rd_req = 1'b0; snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    n_chk++; if (rd_ack !== 1'b0 || rd_data !== 16'd1) $display("FAIL snap_in_resp_hold: got %b/%0d want 0/1", rd_ack, rd_data); else n_pass++;
    do_read(3'd1, 3'd1, d, d8, e, ok);
    n_chk++; if (!ok || d !== 16'd2) $display("FAIL snap_in_resp_new: got %0d want 2", d); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic exp_ack;
    rd_ch = 3'd0; rd_sel = 3'd0; rd_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      exp_ack = (i % 2) == 1;
      n_chk++;
      if (rd_ack !== exp_ack || (exp_ack && rd_data !== 16'd3))
        $display("FAIL b2b_cyc%0d: ack %b data %0d want ack %b data 3", i, rd_ack, rd_data, exp_ack);
      else n_pass++;
    end
    rd_req = 1'b0;
    tick();
  endtask

  task automatic test_rd_err;
    logic [CNT_W-1:0] d; logic [CNT_W8-1:0] d8; logic e, ok;
    do_read(3'd5, 3'd0, d, d8, e, ok);
    n_chk++; if (!ok || e !== 1'b1 || d !== 16'd0) $display("FAIL err_ch5: ack %b err %b data %0d want 1/1/0", ok, e, d); else n_pass++;
    do_read(3'd2, 3'd7, d, d8, e, ok);
    n_chk++; if (!ok || e !== 1'b1 || d !== 16'd0) $display("FAIL err_ch2: ack %b err %b data %0d want 1/1/0", ok, e, d); else n_pass++;
    n_chk++; if (rd_err !== 1'b1) $display("FAIL err_hold: got %b want 1", rd_err); else n_pass++;
    do_read(3'd0, 3'd7, d, d8, e, ok);
    n_chk++; if (!ok || e !== 1'b0 || d !== 16'd2) $display("FAIL err_clear: err %b data %0d want 0/2", e, d); else n_pass++;
  endtask

  task automatic test_reset_in_resp;
    rd_ch = 3'd0; rd_sel = 3'd0; rd_req = 1'b1;
    tick();
    n_chk++; if (rd_ack !== 1'b1 || rd_data !== 16'd3) $display("FAIL pre_rst_ack: got %b/%0d want 1/3", rd_ack, rd_data); else n_pass++;
    rstb = 1'b0;
    #1;
    n_chk++; if (rd_ack !== 1'b0 || rd_data !== '0 || rd_err !== 1'b0) $display("FAIL rst_in_resp: got %b/%0d/%b want 0/0/0", rd_ack, rd_data, rd_err); else n_pass++;
    #2 rstb = 1'b1;
    tick();
    n_chk++; if (rd_ack !== 1'b1 || rd_data !== 16'd0) $display("FAIL post_rst_idle: got %b/%0d want 1/0", rd_ack, rd_data); else n_pass++;
    rd_req = 1'b0;
    tick();
    n_chk++; if (rd_ack !== 1'b0) $display("FAIL post_rst_pulse: got %b want 0", rd_ack); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_cmd_counts();
    test_res_counts();
    test_overflow();
    test_clr_all();
    test_ch_clear();
    test_same_cycle();
    test_back_to_back();
    test_rd_err();
    test_reset_in_resp();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
